seq_shift_add_mult: RTL

- Parametrised sequential shift-add multiplier. Datapath register and control FSM are in one block.
- Takes WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Supports unsigned and signed (two's complement) operands.
- Uses a start/busy/done handshake and a synchronous abort.
- Replaces the separate add/shift register and external controller in the multiplier datapath.

---
 rtl/seq_shift_add_mult.sv | 111 +++++++++++
 1 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one add/shift per multiplier bit, signed via
// magnitude multiply plus a final conditional negate. start/busy/done, sync abort.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH+1;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    // The most negative value negates to itself, which read unsigned is its magnitude.
    mag_a   = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    mag_b   = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
          mcand_d = mag_a;
          count_d = '0;
          neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (acc_q[0])
          acc_d[AW-1:WIDTH] = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {1'b0, acc_q[AW-1:1]};
        if (count_q == CW'(WIDTH-1)) begin
          state_d = FINISH;
        end else begin
          count_d = count_q + 1'b1;
          state_d = ADD;
        end
      end
      FINISH: begin
        prod_d  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Cancel wins over everything, including the FINISH result write.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      prod_d  = prod_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
endmodule
